// File: rtl/mem_access_pkg.sv
// mem_access_pkg: shared encodings for the memory stage (data types, FSM states,
// bus widths, register-file constants).
package mem_access_pkg;
    localparam int BUS_W = 32;
    localparam int BE_W  = BUS_W / 8;
    localparam logic [4:0] REG_ZERO     = 5'd0;
    localparam logic       WRITE_ENABLE = 1'b1;

    typedef enum logic [2:0] {
        DT_NONE   = 3'd0,
        DT_BYTE   = 3'd1,
        DT_HALF   = 3'd2,
        DT_WORD   = 3'd3,
        DT_BYTE_U = 3'd4,
        DT_HALF_U = 3'd5
    } data_type_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2
    } state_e;

    function automatic logic is_byte(input logic [2:0] t);
        return t == DT_BYTE || t == DT_BYTE_U;
    endfunction

    function automatic logic is_half(input logic [2:0] t);
        return t == DT_HALF || t == DT_HALF_U;
    endfunction
endpackage

// File: rtl/mem_access_lane_align.sv
// mem_lane_align: combinational lane logic -- load lane select with sign/zero extension,
// store lane replication, merge into a read word, and byte-enable generation.
module mem_lane_align
    import mem_access_pkg::*;
(
    input  logic [2:0]       data_type_i,
    input  logic [1:0]       addr_lo_i,
    input  logic [BUS_W-1:0] rdata_i,
    input  logic [BUS_W-1:0] sdata_i,
    output logic [BUS_W-1:0] load_o,
    output logic [BUS_W-1:0] merge_o,
    output logic [BUS_W-1:0] rep_o,
    output logic [BE_W-1:0]  be_o
);
    logic [7:0]       b;
    logic [15:0]      h;
    logic [BUS_W-1:0] mask;

    always_comb begin
        b = rdata_i[{addr_lo_i, 3'b000} +: 8];
        h = rdata_i[{addr_lo_i[1], 4'b0000} +: 16];
        load_o = data_type_i == DT_BYTE   ? {{24{b[7]}}, b} :
                 data_type_i == DT_BYTE_U ? {24'b0, b} :
                 data_type_i == DT_HALF   ? {{16{h[15]}}, h} :
                 data_type_i == DT_HALF_U ? {16'b0, h} : rdata_i;
        be_o = is_byte(data_type_i) ? 4'b0001 << addr_lo_i :
               is_half(data_type_i) ? 4'b0011 << {addr_lo_i[1], 1'b0} : 4'hF;
        rep_o = is_byte(data_type_i) ? {4{sdata_i[7:0]}} :
                is_half(data_type_i) ? {2{sdata_i[15:0]}} : sdata_i;
        mask = {{8{be_o[3]}}, {8{be_o[2]}}, {8{be_o[1]}}, {8{be_o[0]}}};
        merge_o = (rep_o & mask) | (rdata_i & ~mask);
    end
endmodule

// File: rtl/mem_access.sv
// mem_access: memory stage -- bus req/ack FSM, load alignment/extension, registered writeback.
// Define MEM_ACCESS_BYTE_STROBE_EN to issue sub-word stores with byte enables instead of read-modify-write.
module mem_access
    import mem_access_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_i,
    input  logic              flush_i,
    input  logic              ex_w_reg_enable_i,
    input  logic              mem_w_reg_enable_i,
    input  logic [4:0]        w_reg_addr_i,
    input  logic [DATA_W-1:0] ex_w_reg_data_i,
    input  logic              r_mem_enable_i,
    input  logic [ADDR_W-1:0] r_mem_addr_i,
    input  logic              w_mem_enable_i,
    input  logic [ADDR_W-1:0] w_mem_addr_i,
    input  logic [DATA_W-1:0] w_mem_data_i,
    input  logic [2:0]        data_type_i,
    output logic              stall_o,
    output logic              bus_req_o,
    output logic              bus_we_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [DATA_W-1:0] bus_wdata_o,
    output logic [3:0]        bus_be_o,
    input  logic              bus_ack_i,
    input  logic [DATA_W-1:0] bus_rdata_i,
    output logic              wb_w_reg_enable_o,
    output logic [4:0]        wb_w_reg_addr_o,
    output logic [DATA_W-1:0] wb_w_reg_data_o,
    output logic              misalign_o,
    output logic              bus_err_o
);
`ifdef MEM_ACCESS_BYTE_STROBE_EN
    localparam bit STROBE = 1'b1;
`else
    localparam bit STROBE = 1'b0;
`endif
    localparam int CNT_W = ACK_TIMEOUT > 1 ? $clog2(ACK_TIMEOUT + 1) : 1;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [2:0]        type_q, type_d;
    logic [4:0]        rd_q, rd_d, wb_addr_q, wb_addr_d;
    logic              wen_q, wen_d, rmw_q, rmw_d;
    logic [DATA_W-1:0] wdata_q, wdata_d, wb_data_q, wb_data_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              wb_en_q, wb_en_d, mis_q, mis_d, err_q, err_d;

    logic              idle, ld, st, mis, direct;
    logic [ADDR_W-1:0] mem_addr;
    logic [2:0]        lane_type;
    logic [1:0]        lane_lo;
    logic [DATA_W-1:0] lane_sdata, lane_load, lane_merge, lane_rep;
    logic [3:0]        lane_be;

    assign idle     = state_q == S_IDLE;
    assign ld       = r_mem_enable_i && !w_mem_enable_i;
    assign st       = w_mem_enable_i;
    assign mem_addr = st ? w_mem_addr_i : r_mem_addr_i;
    assign mis      = (ld || st) && ((is_half(data_type_i) && mem_addr[0]) ||
                      (data_type_i == DT_WORD && mem_addr[1:0] != 2'b00));
    assign direct   = STROBE || !(is_byte(data_type_i) || is_half(data_type_i));

    // In IDLE the lanes see the incoming request; in RD/WR they see the captured one.
    assign lane_type  = idle ? data_type_i : type_q;
    assign lane_lo    = idle ? mem_addr[1:0] : addr_q[1:0];
    assign lane_sdata = idle ? w_mem_data_i : wdata_q;

    mem_lane_align u_lane (
        .data_type_i (lane_type),
        .addr_lo_i   (lane_lo),
        .rdata_i     (bus_rdata_i),
        .sdata_i     (lane_sdata),
        .load_o      (lane_load),
        .merge_o     (lane_merge),
        .rep_o       (lane_rep),
        .be_o        (lane_be)
    );

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        type_d    = type_q;
        rd_d      = rd_q;
        wen_d     = wen_q;
        rmw_d     = rmw_q;
        wdata_d   = wdata_q;
        cnt_d     = cnt_q;
        wb_en_d   = 1'b0;
        wb_addr_d = REG_ZERO;
        wb_data_d = '0;
        mis_d     = 1'b0;
        err_d     = 1'b0;
        if (idle) begin
            cnt_d = '0;
            if (valid_i && !flush_i) begin
                if (mis) begin
                    mis_d = 1'b1;
                end else if (ld || st) begin
                    addr_d  = mem_addr;
                    type_d  = data_type_i;
                    rd_d    = w_reg_addr_i;
                    wen_d   = ld && mem_w_reg_enable_i;
                    rmw_d   = st && !direct;
                    wdata_d = direct ? lane_rep : w_mem_data_i;
                    state_d = (st && direct) ? S_WR : S_RD;
                end else begin
                    wb_en_d   = (ex_w_reg_enable_i == WRITE_ENABLE) && w_reg_addr_i != REG_ZERO;
                    wb_addr_d = wb_en_d ? w_reg_addr_i : REG_ZERO;
                    wb_data_d = wb_en_d ? ex_w_reg_data_i : '0;
                end
            end
        end else if (bus_ack_i) begin
            cnt_d = '0;
            if (state_q == S_WR) begin
                state_d = S_IDLE;
            end else if (rmw_q) begin
                state_d = S_WR;
                wdata_d = lane_merge;
            end else begin
                state_d   = S_IDLE;
                wb_en_d   = (wen_q == WRITE_ENABLE) && rd_q != REG_ZERO;
                wb_addr_d = wb_en_d ? rd_q : REG_ZERO;
                wb_data_d = wb_en_d ? lane_load : '0;
            end
        end else if (ACK_TIMEOUT != 0 && cnt_q == CNT_W'(ACK_TIMEOUT - 1)) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            err_d   = 1'b1;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            type_q    <= '0;
            rd_q      <= '0;
            wen_q     <= 1'b0;
            rmw_q     <= 1'b0;
            wdata_q   <= '0;
            cnt_q     <= '0;
            wb_en_q   <= 1'b0;
            wb_addr_q <= '0;
            wb_data_q <= '0;
            mis_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            type_q    <= type_d;
            rd_q      <= rd_d;
            wen_q     <= wen_d;
            rmw_q     <= rmw_d;
            wdata_q   <= wdata_d;
            cnt_q     <= cnt_d;
            wb_en_q   <= wb_en_d;
            wb_addr_q <= wb_addr_d;
            wb_data_q <= wb_data_d;
            mis_q     <= mis_d;
            err_q     <= err_d;
        end
    end

    assign stall_o           = !idle;
    assign bus_req_o         = !idle;
    assign bus_we_o          = state_q == S_WR;
    assign bus_addr_o        = idle ? '0 : {addr_q[ADDR_W-1:2], 2'b00};
    assign bus_wdata_o       = bus_we_o ? wdata_q : '0;
    assign bus_be_o          = idle ? 4'h0 : (STROBE && bus_we_o) ? lane_be : 4'hF;
    assign wb_w_reg_enable_o = wb_en_q;
    assign wb_w_reg_addr_o   = wb_addr_q;
    assign wb_w_reg_data_o   = wb_data_q;
    assign misalign_o        = mis_q;
    assign bus_err_o         = err_q;
endmodule
